// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and access-decode helpers for the MEM-stage load/store unit.
package lsu_pkg;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t IDLE = 2'd0;
  localparam lsu_state_t REQ  = 2'd1;
  localparam lsu_state_t RESP = 2'd2;
  localparam lsu_state_t DONE = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_bytes = 4'd1;
      F3_H, F3_HU: size_bytes = 4'd2;
      F3_W, F3_WU: size_bytes = 4'd4;
      default:     size_bytes = 4'd8;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] off);
    case (size_bytes(funct3))
      4'd1:    is_aligned = 1'b1;
      4'd2:    is_aligned = (off[0] == 1'b0);
      4'd4:    is_aligned = (off[1:0] == 2'b00);
      default: is_aligned = (off == 3'b000);
    endcase
  endfunction

  // Unsigned-load encodings have no store counterpart; 64-bit widths need XLEN=64.
  function automatic logic is_legal(input logic [2:0] funct3, input logic we,
                                    input int unsigned xlen);
    case (funct3)
      F3_B, F3_H, F3_W: is_legal = 1'b1;
      F3_D:             is_legal = (xlen == 64);
      F3_BU, F3_HU:     is_legal = ~we;
      F3_WU:            is_legal = ~we & (xlen == 64);
      default:          is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/response bus between the load/store unit (master) and memory (slave).
interface lsu_mem_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned NBYTES = XLEN / 8;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [NBYTES-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/byte-enable placement and load extraction with extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned NBYTES = XLEN / 8,
  localparam int unsigned OFF_W = $clog2(NBYTES)
) (
  input  logic [2:0]        stFunct3_i,
  input  logic [OFF_W-1:0]  stOff_i,
  input  logic [XLEN-1:0]   stWdata_i,
  output logic [NBYTES-1:0] be_o,
  output logic [XLEN-1:0]   wdata_o,
  input  logic [2:0]        ldFunct3_i,
  input  logic [OFF_W-1:0]  ldOff_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [XLEN-1:0]   ldData_o
);
  logic [3:0]        stSize;
  logic [NBYTES-1:0] stMask;
  logic [3:0]        ldSize;
  logic [XLEN-1:0]   shifted;
  logic              signBit;

  always_comb begin
    stSize = size_bytes(stFunct3_i);
    stMask = '0;
    for (int i = 0; i < NBYTES; i++) stMask[i] = (i < int'(stSize));
    be_o    = stMask << stOff_i;
    wdata_o = stWdata_i << {stOff_i, 3'b000};
  end

  always_comb begin
    shifted = rdata_i >> {ldOff_i, 3'b000};
    ldSize  = size_bytes(ldFunct3_i);
    signBit = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i == int'(ldSize) - 1) signBit = shifted[8*i+7];
    end
    // funct3[2] clear marks the sign-extending loads.
    for (int i = 0; i < XLEN; i++) begin
      ldData_o[i] = (i < 8 * int'(ldSize)) ? shifted[i] : (~ldFunct3_i[2] & signBit);
    end
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: stalls the pipeline across a variable-latency memory access
// and flags misaligned accesses instead of issuing them.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned NBYTES = XLEN / 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stallM,
  output logic              misalignM,
  output logic              load_valid,
  output logic [XLEN-1:0]   load_data,
  lsu_mem_stage_if.master   mem
);
  localparam int unsigned OFF_W = $clog2(NBYTES);

  lsu_state_t        stateQ, stateD;
  logic [ADDR_W-1:0] addrQ;
  logic              weQ;
  logic [2:0]        funct3Q;
  logic [OFF_W-1:0]  offQ;
  logic [NBYTES-1:0] beQ;
  logic [XLEN-1:0]   wdataQ;
  logic [XLEN-1:0]   loadDataQ;

  logic [OFF_W-1:0]  reqOff;
  logic              reqLegal, reqAligned, reqGo;
  logic [NBYTES-1:0] stBe;
  logic [XLEN-1:0]   stWdata, ldData;

  assign reqOff     = req_addr[OFF_W-1:0];
  assign reqLegal   = is_legal(req_funct3, req_we, XLEN);
  assign reqAligned = is_aligned(req_funct3, 3'(reqOff));
  assign reqGo      = req_valid & reqLegal & reqAligned;

  lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
    .stFunct3_i (req_funct3),
    .stOff_i    (reqOff),
    .stWdata_i  (req_wdata),
    .be_o       (stBe),
    .wdata_o    (stWdata),
    .ldFunct3_i (funct3Q),
    .ldOff_i    (offQ),
    .rdata_i    (mem.mem_rdata),
    .ldData_o   (ldData)
  );

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (reqGo) stateD = REQ;
      REQ:     if (mem.mem_req_ready) stateD = weQ ? DONE : RESP;
      RESP:    if (mem.mem_rsp_valid) stateD = DONE;
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stateQ    <= IDLE;
      addrQ     <= '0;
      weQ       <= 1'b0;
      funct3Q   <= '0;
      offQ      <= '0;
      beQ       <= '0;
      wdataQ    <= '0;
      loadDataQ <= '0;
    end else begin
      stateQ <= stateD;
      if (stateQ == IDLE && reqGo) begin
        addrQ   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        weQ     <= req_we;
        funct3Q <= req_funct3;
        offQ    <= reqOff;
        beQ     <= stBe;
        wdataQ  <= stWdata;
      end
      if (stateQ == RESP && mem.mem_rsp_valid) loadDataQ <= ldData;
    end
  end

  assign stallM     = ~clr & reqGo & (stateQ != DONE);
  assign misalignM  = ~clr & req_valid & reqLegal & ~reqAligned & (stateQ == IDLE);
  assign load_valid = (stateQ == DONE) & ~weQ;
  assign load_data  = loadDataQ;

  assign mem.mem_req_valid = (stateQ == REQ);
  assign mem.mem_addr      = addrQ;
  assign mem.mem_we        = weQ;
  assign mem.mem_be        = beQ;
  assign mem.mem_wdata     = wdataQ;

  // The pipeline keeps the MEM-stage instruction in place until the access completes.
  reqHeldA: assert property (@(posedge clk) disable iff (clr) (stateQ != IDLE) |-> req_valid);

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Drives 32- and 64-bit LSU instances with shared stimulus and checks both against a
// transaction-level reference model.
module tb_lsu_mem_stage;
  logic        clk = 1'b0;
  logic        clr;
  logic        reqValid, reqWe;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [63:0] reqWdata, memRdata;
  logic        memReady, memRspValid;

  logic        stall32, mis32, lv32;
  logic [31:0] ld32;
  logic        stall64, mis64, lv64;
  logic [63:0] ld64;

  int          nChecks = 0;
  int          nPass = 0;
  logic [63:0] lastLd [2];

  always #5 clk = ~clk;

  lsu_mem_stage_if #(.XLEN(32), .ADDR_W(32)) mif32 ();
  lsu_mem_stage_if #(.XLEN(64), .ADDR_W(32)) mif64 ();

  assign mif32.mem_req_ready = memReady;
  assign mif32.mem_rsp_valid = memRspValid;
  assign mif32.mem_rdata     = memRdata[31:0];
  assign mif64.mem_req_ready = memReady;
  assign mif64.mem_rsp_valid = memRspValid;
  assign mif64.mem_rdata     = memRdata;

  lsu_mem_stage #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (reqValid),
    .req_we     (reqWe),
    .req_funct3 (reqFunct3),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata[31:0]),
    .stallM     (stall32),
    .misalignM  (mis32),
    .load_valid (lv32),
    .load_data  (ld32),
    .mem        (mif32)
  );

  lsu_mem_stage #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (reqValid),
    .req_we     (reqWe),
    .req_funct3 (reqFunct3),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .stallM     (stall64),
    .misalignM  (mis64),
    .load_valid (lv64),
    .load_data  (ld64),
    .mem        (mif64)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic bit legal_m(input int xlen, input logic we, input logic [2:0] f3);
    if (f3 == 3'd7) return 1'b0;
    if (we && f3 >= 3'd4) return 1'b0;
    if (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit aligned_m(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = 1 << f3[1:0];
    int unsigned ua = addr;
    return (ua % sz) == 0;
  endfunction

  function automatic logic [63:0] xmask_m(input int xlen);
    return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic int unsigned off_m(input int xlen, input logic [31:0] addr);
    int unsigned ua = addr;
    return ua % (xlen / 8);
  endfunction

  function automatic logic [63:0] be_m(input int xlen, input logic [2:0] f3,
                                       input logic [31:0] addr);
    int unsigned sz = 1 << f3[1:0];
    int unsigned nb = xlen / 8;
    logic [63:0] m = ((64'd1 << sz) - 64'd1) << off_m(xlen, addr);
    return m & ((64'd1 << nb) - 64'd1);
  endfunction

  function automatic logic [63:0] wdata_m(input int xlen, input logic [31:0] addr,
                                          input logic [63:0] wdata);
    logic [63:0] w = wdata & xmask_m(xlen);
    return (w << (8 * off_m(xlen, addr))) & xmask_m(xlen);
  endfunction

  function automatic logic [63:0] load_m(input int xlen, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [63:0] rdata);
    int unsigned sz = 1 << f3[1:0];
    logic [63:0] smask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    logic [63:0] v = ((rdata & xmask_m(xlen)) >> (8 * off_m(xlen, addr))) & smask;
    if (!f3[2] && v[8*sz-1]) v = v | ~smask;
    return v & xmask_m(xlen);
  endfunction

  // Check one DUT in cycle c of a transaction whose request is accepted in cycle a.
  task automatic check_dut(input int xlen, input int c, input int a, input int doneCyc,
                           input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rdata);
    int          k = (xlen == 64) ? 1 : 0;
    bit          leg = legal_m(xlen, we, f3);
    bit          act = leg && aligned_m(f3, addr);
    bit          inReq = act && c >= 1 && c <= a;
    string       p = (xlen == 64) ? "x64" : "x32";
    logic        st, mi, lv, mrv, mwe;
    logic [63:0] ld, mbe, mwd;
    logic [31:0] mad;
    if (xlen == 64) begin
      st = stall64; mi = mis64; lv = lv64; ld = ld64; mrv = mif64.mem_req_valid;
      mwe = mif64.mem_we; mbe = 64'(mif64.mem_be); mwd = mif64.mem_wdata; mad = mif64.mem_addr;
    end else begin
      st = stall32; mi = mis32; lv = lv32; ld = 64'(ld32); mrv = mif32.mem_req_valid;
      mwe = mif32.mem_we; mbe = 64'(mif32.mem_be); mwd = 64'(mif32.mem_wdata);
      mad = mif32.mem_addr;
    end
    check_val({p, " stallM"}, 64'(st), 64'(act && c < doneCyc));
    check_val({p, " misalignM"}, 64'(mi), 64'(leg && !aligned_m(f3, addr)));
    check_val({p, " mem_req_valid"}, 64'(mrv), 64'(inReq));
    if (inReq) begin
      check_val({p, " mem_addr"}, 64'(mad), 64'(addr & ~((xlen / 8) - 1)));
      check_val({p, " mem_we"}, 64'(mwe), 64'(we));
      check_val({p, " mem_be"}, mbe, be_m(xlen, f3, addr));
      check_val({p, " mem_wdata"}, mwd, wdata_m(xlen, addr, wdata));
    end
    check_val({p, " load_valid"}, 64'(lv), 64'(act && !we && c == doneCyc));
    if (act && !we && c == doneCyc) lastLd[k] = load_m(xlen, f3, addr, rdata);
    check_val({p, " load_data"}, ld, lastLd[k]);
  endtask

  // wr: cycles ready stays low in REQ; wp: extra cycles between acceptance and response.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input int wr, input int wp);
    bit any = (legal_m(64, we, f3) || legal_m(32, we, f3)) && aligned_m(f3, addr);
    int a = 1 + wr;
    int doneCyc = !any ? 0 : (we ? a + 1 : a + 2 + wp);
    reqValid = 1'b1; reqWe = we; reqFunct3 = f3; reqAddr = addr;
    reqWdata = wdata; memRdata = rdata;
    for (int c = 0; c <= doneCyc; c++) begin
      memReady    = (c >= a);
      memRspValid = any && !we && (c >= a + 1 + wp);
      @(negedge clk);
      check_dut(32, c, a, doneCyc, we, f3, addr, wdata, rdata);
      check_dut(64, c, a, doneCyc, we, f3, addr, wdata, rdata);
      @(posedge clk); #1;
    end
    reqValid = 1'b0; memReady = 1'b0; memRspValid = 1'b0;
  endtask

  // Bubble cycle with junk on the bus and a stray response that must be ignored.
  task automatic idle_cycle();
    reqValid = 1'b0; reqFunct3 = 3'($urandom); reqAddr = $urandom;
    memReady = 1'($urandom); memRspValid = 1'b1; memRdata = {$urandom, $urandom};
    @(negedge clk);
    check_val("idle x32 stallM", 64'(stall32), 64'd0);
    check_val("idle x64 stallM", 64'(stall64), 64'd0);
    check_val("idle x32 misalignM", 64'(mis32), 64'd0);
    check_val("idle x64 req_valid", 64'(mif64.mem_req_valid), 64'd0);
    check_val("idle x32 load_valid", 64'(lv32), 64'd0);
    check_val("idle x64 load_data", ld64, lastLd[1]);
    @(posedge clk); #1;
    memRspValid = 1'b0; memReady = 1'b0;
  endtask

  initial begin
    clr = 1'b1; reqValid = 1'b1; reqWe = 1'b0; reqFunct3 = 3'd2; reqAddr = 32'h3000;
    reqWdata = '0; memRdata = '0; memReady = 1'b1; memRspValid = 1'b1;
    lastLd[0] = '0; lastLd[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst x32 stallM", 64'(stall32), 64'd0);
    check_val("rst x64 stallM", 64'(stall64), 64'd0);
    check_val("rst x64 mem_req_valid", 64'(mif64.mem_req_valid), 64'd0);
    check_val("rst x32 mem_be", 64'(mif32.mem_be), 64'd0);
    check_val("rst x64 load_data", ld64, 64'd0);
    check_val("rst x32 load_valid", 64'(lv32), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0; reqValid = 1'b0; memReady = 1'b0; memRspValid = 1'b0;
    @(posedge clk); #1;

    run_txn(1'b1, 3'd0, 32'h1003, 64'h0000_00AB, 64'd0, 0, 0);           // sb
    run_txn(1'b0, 3'd1, 32'h2002, 64'd0, 64'h0000_0000_8001_1234, 0, 1); // lh
    run_txn(1'b0, 3'd5, 32'h2002, 64'd0, 64'h0000_0000_8001_1234, 0, 1); // lhu
    run_txn(1'b0, 3'd2, 32'h3001, 64'd0, 64'd0, 0, 0);                   // misaligned lw
    run_txn(1'b0, 3'd2, 32'h0040, 64'd0, 64'h1234_5678_9ABC_DEF0, 5, 0); // ready held low

    // clr while waiting for the response; the late response must be dropped.
    reqValid = 1'b1; reqWe = 1'b0; reqFunct3 = 3'd2; reqAddr = 32'h40;
    memRdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    memReady = 1'b1;
    @(posedge clk); #1;
    memReady = 1'b0; clr = 1'b1; reqValid = 1'b0;
    #1;
    check_val("clr x32 stallM", 64'(stall32), 64'd0);
    check_val("clr x64 mem_req_valid", 64'(mif64.mem_req_valid), 64'd0);
    check_val("clr x64 mem_addr", 64'(mif64.mem_addr), 64'd0);
    check_val("clr x32 load_data", 64'(ld32), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0; memRspValid = 1'b1;
    @(negedge clk);
    check_val("clr rsp x32 load_valid", 64'(lv32), 64'd0);
    check_val("clr rsp x64 stallM", 64'(stall64), 64'd0);
    @(posedge clk); #1;
    memRspValid = 1'b0;
    @(negedge clk);
    check_val("clr rsp x64 load_valid", 64'(lv64), 64'd0);
    check_val("clr rsp x64 load_data", ld64, 64'd0);
    check_val("clr rsp x32 mem_req_valid", 64'(mif32.mem_req_valid), 64'd0);
    lastLd[0] = '0; lastLd[1] = '0;
    @(posedge clk); #1;

    run_txn(1'b0, 3'd6, 32'h0014, 64'd0, 64'hDEAD_BEEF_0000_0000, 0, 0); // lwu
    run_txn(1'b0, 3'd3, 32'h0010, 64'd0, 64'h8877_6655_4433_2211, 1, 2); // ld
    run_txn(1'b0, 3'd3, 32'h0014, 64'd0, 64'd0, 0, 0);                   // misaligned ld
    run_txn(1'b1, 3'd3, 32'h0018, 64'h0102_0304_0506_0708, 64'd0, 0, 0); // sd

    for (int n = 0; n < 300; n++) begin
      run_txn(1'($urandom), 3'($urandom), 32'($urandom_range(0, 255)),
              {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
